parity_sweep_ctrl: RTL and testbench

//  Sequencer/self-checker for the 9-bit counter + HC280 parity generator datapath.
//  On a start request it clears the counter, then enables it for SWEEP_LEN counts.

---
 rtl/parity_sweep_ctrl.sv | 107 ++++++++++
 tb/tb_parity_sweep_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/parity_sweep_ctrl.sv
// Sequencer and self-checker for the 9-bit counter + HC280 parity datapath.
// Clears the counter, sweeps SWEEP_LEN counts, and checks parity and count against the index.
module parity_sweep_ctrl #(
    parameter int SWEEP_LEN = 512,
    parameter bit CHK_COUNT = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       abort,
    input  logic [8:0] count,
    input  logic       even_out,
    input  logic       odd_out,
    output logic       ctr_enable,
    output logic       ctr_clr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_cnt,
    output logic [8:0] first_err_val,
    output logic       first_err_vld
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [8:0] LAST = 9'(SWEEP_LEN - 1);

    state_t     state, state_nxt;
    logic [8:0] idx;
    logic       chk_err;
    logic [9:0] err_cnt_nxt;

    // Check runs on the live inputs every RUN cycle, including the one where abort is seen.
    always_comb begin
        chk_err = (odd_out != ^idx) || (even_out != ~^idx) || (CHK_COUNT && (count != idx));
        err_cnt_nxt = err_cnt;
        if (state == RUN && chk_err && err_cnt != 10'h3FF)
            err_cnt_nxt = err_cnt + 10'd1;
    end

    always_comb begin
        state_nxt  = state;
        ctr_enable = 1'b0;
        ctr_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                ctr_clr   = 1'b1;
                busy      = 1'b1;
                state_nxt = abort ? IDLE : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                // Counter holds on the final index so it never runs past the sweep.
                ctr_enable = (idx != LAST);
                if (abort)            state_nxt = IDLE;
                else if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= IDLE;
            idx           <= 9'd0;
            err_cnt       <= 10'd0;
            first_err_val <= 9'd0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= 9'd0;
                        err_cnt       <= 10'd0;
                        first_err_val <= 9'd0;
                        first_err_vld <= 1'b0;
                        pass          <= 1'b0;
                    end
                end
                CLEAR: idx <= 9'd0;
                RUN: begin
                    err_cnt <= err_cnt_nxt;
                    if (chk_err && !first_err_vld) begin
                        first_err_val <= idx;
                        first_err_vld <= 1'b1;
                    end
                    if (idx != LAST) idx <= idx + 9'd1;
                    // pass must include the final cycle's check, hence err_cnt_nxt.
                    if (state_nxt == DONE) pass <= (err_cnt_nxt == 10'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// Scoreboard bench for parity_sweep_ctrl: behavioural counter + HC280 models with injectable faults.
module tb_parity_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1, start = 1'b0, abort = 1'b0, start4 = 1'b0;
    bit   stuck = 1'b0, jump = 1'b0;

    // full-length instance, count checking on
    logic [8:0] cnt = 9'd0, count;
    logic       even_out, odd_out, ctr_enable, ctr_clr, busy, done, pass, first_err_vld;
    logic [9:0] err_cnt;
    logic [8:0] first_err_val;

    always @(posedge clk)
        if (ctr_clr)         cnt <= 9'd0;
        else if (ctr_enable) cnt <= (jump && cnt == 9'h0FE) ? 9'h100 : cnt + 9'd1;
    assign count    = cnt;
    assign even_out = ~^cnt;
    assign odd_out  = stuck ? 1'b0 : ^cnt;

    parity_sweep_ctrl dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .count(count),
        .even_out(even_out), .odd_out(odd_out), .ctr_enable(ctr_enable), .ctr_clr(ctr_clr),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_val(first_err_val), .first_err_vld(first_err_vld)
    );

    // short instance, parity-only; count bus is corrupted in a parity-preserving way
    logic [8:0] cnt4 = 9'd0, count4;
    logic       ctr_enable4, ctr_clr4, busy4, done4, pass4, first_err_vld4;
    logic [9:0] err_cnt4;
    logic [8:0] first_err_val4;

    always @(posedge clk)
        if (ctr_clr4)         cnt4 <= 9'd0;
        else if (ctr_enable4) cnt4 <= cnt4 + 9'd1;
    assign count4 = cnt4 ^ 9'h003;

    parity_sweep_ctrl #(.SWEEP_LEN(4), .CHK_COUNT(1'b0)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .abort(1'b0), .count(count4),
        .even_out(~^cnt4), .odd_out(^cnt4), .ctr_enable(ctr_enable4), .ctr_clr(ctr_clr4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err_cnt4),
        .first_err_val(first_err_val4), .first_err_vld(first_err_vld4)
    );

    typedef struct {
        int ec;
        int fv;
        bit fvld;
        bit pass;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference sweep from the datapath's point of view: what count/parity each index sees.
    function automatic void ref_sweep(input bit stk, input bit jmp, input bit chk_cnt, input int n,
                                      output int ec, output int fv, output bit fvld);
        logic [8:0] i9, c;
        logic       o, e;
        ec = 0; fv = 0; fvld = 1'b0;
        for (int i = 0; i < n; i++) begin
            i9 = 9'(i);
            c  = (jmp && i >= 255) ? 9'(i + 1) : i9;
            o  = stk ? 1'b0 : ^c;
            e  = ~^c;
            if (o != ^i9 || e != ~^i9 || (chk_cnt && c != i9)) begin
                if (ec < 1023) ec++;
                if (!fvld) begin fv = i; fvld = 1'b1; end
            end
        end
    endfunction

    task automatic run_sweep(input string name, input bit stk, input bit jmp);
        exp_t e;
        int   ec, fv, bc;
        bit   fvld, seen;
        stuck = stk; jump = jmp;
        ref_sweep(stk, jmp, 1'b1, 512, ec, fv, fvld);
        e.ec = ec; e.fv = fv; e.fvld = fvld; e.pass = (ec == 0);
        sb.push_back(e);
        start = 1'b1; bc = 0; seen = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (done) begin seen = 1'b1; break; end
        end
        chk({name, "_done_seen"}, seen, 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_busy_cycles"}, bc, 513);
            chk({name, "_err_cnt"}, err_cnt, e.ec);
            chk({name, "_first_val"}, first_err_val, e.fv);
            chk({name, "_first_vld"}, first_err_vld, e.fvld);
            chk({name, "_pass"}, pass, e.pass);
        end
        @(negedge clk);
        chk({name, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int  ec, fv, bc;
        bit  fvld, seen;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", ctr_enable, 0);
        chk("rst_clr", ctr_clr, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fvld", first_err_vld, 0);
        clr = 1'b0;
        @(negedge clk);

        run_sweep("ideal", 1'b0, 1'b0);
        run_sweep("odd_stuck", 1'b1, 1'b0);
        run_sweep("jump", 1'b0, 1'b1);
        jump = 1'b0;

        // abort at idx 100 with odd stuck, so the held count is non-zero
        stuck = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("abort_clear_phase", ctr_clr, 1);
        repeat (101) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        ref_sweep(1'b1, 1'b0, 1'b1, 101, ec, fv, fvld);
        chk("abort_busy", busy, 0);
        chk("abort_en", ctr_enable, 0);
        chk("abort_err", err_cnt, ec);
        chk("abort_fval", first_err_val, fv);
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("abort_no_done", seen, 0);
        chk("abort_err_held", err_cnt, ec);

        // clr mid-run at idx 300, start held during clr
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (301) @(negedge clk);
        chk("pre_clr_busy", busy, 1);
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_en", ctr_enable, 0);
        chk("clr_err", err_cnt, 0);
        chk("clr_fvld", first_err_vld, 0);
        chk("clr_fval", first_err_val, 0);
        repeat (3) @(negedge clk);
        chk("clr_start_ignored", busy, 0);
        chk("clr_ctr_clr", ctr_clr, 0);
        clr = 1'b0; start = 1'b0; stuck = 1'b0;
        @(negedge clk);
        chk("post_clr_idle", busy, 0);

        // SWEEP_LEN=4, parity-only, start held high
        ref_sweep(1'b0, 1'b0, 1'b0, 4, ec, fv, fvld);
        e.ec = ec; e.fv = fv; e.fvld = fvld; e.pass = (ec == 0);
        sb.push_back(e);
        start4 = 1'b1; bc = 0; seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy4) bc++;
            if (done4) begin seen = 1'b1; break; end
        end
        chk("s4_done_seen", seen, 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("s4_busy_cycles", bc, 5);
            chk("s4_err", err_cnt4, e.ec);
            chk("s4_pass", pass4, e.pass);
        end
        @(negedge clk);
        chk("s4_idle_gap", busy4, 0);
        @(negedge clk);
        chk("s4_restart_busy", busy4, 1);
        chk("s4_restart_clr", ctr_clr4, 1);
        start4 = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
